alu_seq_muldiv: RTL
===================

Name: alu_seq_muldiv

Overview:
- Parametrised, sequential successor to the single-cycle ALU top: same opcode/func_field decode, registered results, plus iterative MIPS mult/multu/div/divu with architectural HI/LO registers and mfhi/mflo.
- Sits in the execute stage of the multi-cycle datapath.
- Controller drives operands with a valid/ready handshake and waits for out_valid.

Parameters:
- WIDTH, 32, operand/result width; even, >= 4.
- ENABLE_MULDIV, 1, 1 = mult/div/mfhi/mflo implemented; 0 = those funcs decode as illegal.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- opcode  in  6  MIPS primary opcode.
- func_field  in  6  MIPS funct, used when opcode==0x00.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt / immediate (already extended).
- out_valid  out  1  one-cycle pulse: result/flags valid.
- result  out  WIDTH  registered result.
- zero  out  1  result==0; for mult/div, {HI,LO}==0.
- overflow  out  1  signed overflow of add/sub/addi; 0 otherwise.
- illegal  out  1  undecoded opcode/func; result=0.
- busy  out  1  mult/div in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: all outputs 0 except in_ready=1; HI=LO=0; state=IDLE. Reset mid-operation aborts the operation with no HI/LO update and no out_valid.
- Accept: on a clk edge where in_valid && in_ready; accepting cycle = N. Inputs are ignored otherwise.
- Decode:
  - opcode 0x23/0x2B/0x08 -> add.
  - opcode 0x04/0x05 -> sub.
  - opcode 0x0C -> and.
  - opcode 0x0D -> or.
  - opcode 0x0A -> slt.
  - opcode 0x00 funct: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x12 mflo.
  - Anything else -> illegal=1 with out_valid at N+1.
- Simple ops (logic/add/sub/slt/mfhi/mflo/illegal): out_valid=1 in cycle N+1; in_ready stays high, so back-to-back issue is allowed.
  - overflow is set only for signed add/sub when operand signs force a wrong result sign.
  - slt/sltu return 1 or 0 zero-extended.
- FSM IDLE -> BUSY -> FINISH -> IDLE, for mult/div only:
  - IDLE: on accept of a mult/div, latch operand magnitudes (signed ops take abs and record the result signs), counter=0, go to BUSY; in_ready=0, busy=1.
  - BUSY: one radix-2 step per cycle (shift-add multiply / restoring divide). Counter runs 0..WIDTH-1; at WIDTH-1 go to FINISH.
  - FINISH: apply sign correction, write HI/LO, out_valid=1 in cycle N+WIDTH+2, go to IDLE; in_ready=1 from the following cycle.
- Mult/div results:
  - mult: {HI,LO} = full 2*WIDTH product. result = LO.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign. result = LO.
  - Divide by zero: LO = all ones, HI = A. No exception; no extra latency.
  - Signed div of MIN/-1: LO = MIN, HI = 0.
- Outputs hold their last values between out_valid pulses; out_valid is never held high for more than one cycle.
- ENABLE_MULDIV=0: FSM is removed, hi/lo tie to 0, busy=0.

Decomposition:
- Package alu_seq_pkg holds the opcode and funct localparams, the internal op enum (ALU_ADD..ALU_MFLO, ALU_ILLEGAL), and the FSM state enum.
- Sub-module muldiv_iter, parametrised WIDTH, contains the iterative engine: start, signed, is_div, a, b -> done, hi, lo.
- The top module holds decode, the single-cycle datapath, the handshake and the HI/LO registers.

Test Plan (WIDTH=32):
- A=0x2222, B=0x1111, opcode 0x00/func 0x20 -> out_valid at N+1, result=0x3333, zero=0. Then func 0x24 -> 0x0000, zero=1. Then opcode 0x23 -> 0x3333. Then A=B=0x5555, opcode 0x04 -> result 0, zero=1. Then A=0x1111, B=0x2222, func 0x2A -> result 1.
- A=0x7FFFFFFF, B=1, func 0x20 -> result 0x80000000, overflow=1. Same operands with func 0x21 -> overflow=0.
- mult, A=0xFFFFFFFD (-3), B=7 -> in_ready low cycles N+1..N+34, out_valid at N+34, HI=0xFFFFFFFF, LO=0xFFFFFFEB. mfhi next -> 0xFFFFFFFF at +1.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
- In-flight multu, assert reset at N+10 -> next cycle in_ready=1, busy=0, HI=LO=0, no out_valid pulse. in_valid held during BUSY is not accepted.
- opcode 0x3F -> illegal=1, result=0, out_valid at N+1. funct 0x18 with ENABLE_MULDIV=0 -> illegal=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared decode constants, internal op/state enums and the opcode/funct decoder
// for the sequential ALU with iterative multiply/divide.
package alu_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO,
    ALU_ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_FINISH} md_state_e;

  // Mult/div/mfhi/mflo fall back to illegal when the engine is not built.
  function automatic alu_op_e decodeOp(input logic [5:0] opcode, input logic [5:0] funct,
                                       input logic enMulDiv);
    alu_op_e op;
    op = ALU_ILLEGAL;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI: op = ALU_ADD;
      OP_BEQ, OP_BNE:        op = ALU_SUB;
      OP_ANDI:               op = ALU_AND;
      OP_ORI:                op = ALU_OR;
      OP_SLTI:               op = ALU_SLT;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:   op = ALU_ADD;
          FN_ADDU:  op = ALU_ADDU;
          FN_SUB:   op = ALU_SUB;
          FN_SUBU:  op = ALU_SUBU;
          FN_AND:   op = ALU_AND;
          FN_OR:    op = ALU_OR;
          FN_XOR:   op = ALU_XOR;
          FN_NOR:   op = ALU_NOR;
          FN_SLT:   op = ALU_SLT;
          FN_SLTU:  op = ALU_SLTU;
          FN_MULT:  op = enMulDiv ? ALU_MULT  : ALU_ILLEGAL;
          FN_MULTU: op = enMulDiv ? ALU_MULTU : ALU_ILLEGAL;
          FN_DIV:   op = enMulDiv ? ALU_DIV   : ALU_ILLEGAL;
          FN_DIVU:  op = enMulDiv ? ALU_DIVU  : ALU_ILLEGAL;
          FN_MFHI:  op = enMulDiv ? ALU_MFHI  : ALU_ILLEGAL;
          FN_MFLO:  op = enMulDiv ? ALU_MFLO  : ALU_ILLEGAL;
          default:  op = ALU_ILLEGAL;
        endcase
      end
      default: op = ALU_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply and restoring divide on operand
// magnitudes, with sign correction applied while in FINISH.
module muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state;
  logic [CW-1:0]      r_count;
  logic               r_isDiv, r_negRes, r_negA, r_divZero;
  logic [WIDTH-1:0]   r_aOrig, r_operand, r_upper, r_lower;

  logic [WIDTH-1:0]   w_absA, w_absB, w_nextUpper, w_nextLower;
  logic [WIDTH:0]     w_addSum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;

  assign w_absA = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_absB = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // upper/lower double as product-high/multiplier for mult and remainder/quotient for div
  assign w_addSum = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_operand} : '0);
  assign w_shift  = {r_upper, r_lower[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_operand};

  always_comb begin
    w_nextUpper = '0;
    w_nextLower = '0;
    if (r_isDiv) begin
      if (!w_diff[WIDTH]) begin
        w_nextUpper = w_diff[WIDTH-1:0];
        w_nextLower = {r_lower[WIDTH-2:0], 1'b1};
      end else begin
        w_nextUpper = w_shift[WIDTH-1:0];
        w_nextLower = {r_lower[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_nextUpper = w_addSum[WIDTH:1];
      w_nextLower = {w_addSum[0], r_lower[WIDTH-1:1]};
    end
  end

  assign w_prod    = {r_upper, r_lower};
  assign w_prodFix = r_negRes ? -w_prod : w_prod;

  // A zero divisor yields an all-ones quotient naturally; HI must carry the raw dividend.
  always_comb begin
    o_hi = w_prodFix[2*WIDTH-1:WIDTH];
    o_lo = w_prodFix[WIDTH-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        o_hi = r_aOrig;
        o_lo = '1;
      end else begin
        o_hi = r_negA   ? -r_upper : r_upper;
        o_lo = r_negRes ? -r_lower : r_lower;
      end
    end
  end

  assign o_done = (r_state == MD_FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MD_IDLE;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negA    <= 1'b0;
      r_divZero <= 1'b0;
      r_aOrig   <= '0;
      r_operand <= '0;
      r_upper   <= '0;
      r_lower   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_isDiv   <= i_isDiv;
            r_negRes  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_negA    <= i_signed && i_a[WIDTH-1];
            r_divZero <= i_isDiv && (i_b == '0);
            r_aOrig   <= i_a;
            r_operand <= i_isDiv ? w_absB : w_absA;
            r_upper   <= '0;
            r_lower   <= i_isDiv ? w_absA : w_absB;
            r_count   <= '0;
            r_state   <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_upper <= w_nextUpper;
          r_lower <= w_nextLower;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) r_state <= MD_FINISH;
        end
        MD_FINISH: r_state <= MD_IDLE;
        default:   r_state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU: single-cycle ops answered one cycle after accept, plus
// iterative mult/div writing the architectural HI/LO registers.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_op_e          w_op;
  logic             w_accept, w_mdStart, w_mdDone, w_ovf, w_ill;
  logic [WIDTH-1:0] w_sum, w_diff, w_res, w_mdHi, w_mdLo;

  logic             r_inReady, r_busy, r_finish, r_outValid, r_zero, r_overflow, r_illegal;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;

  assign w_op      = decodeOp(opcode, func_field, ENABLE_MULDIV != 0);
  assign w_accept  = in_valid && r_inReady;
  assign w_mdStart = w_accept && (w_op == ALU_MULT || w_op == ALU_MULTU ||
                                  w_op == ALU_DIV  || w_op == ALU_DIVU);
  assign w_sum     = A + B;
  assign w_diff    = A - B;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_ADDU: w_res = w_sum;
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUBU:    w_res = w_diff;
      ALU_AND:     w_res = A & B;
      ALU_OR:      w_res = A | B;
      ALU_XOR:     w_res = A ^ B;
      ALU_NOR:     w_res = ~(A | B);
      ALU_SLT:     w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU:    w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_MFHI:    w_res = r_hi;
      ALU_MFLO:    w_res = r_lo;
      ALU_ILLEGAL: w_ill = 1'b1;
      default:     w_res = '0;
    endcase
  end

  generate
    if (ENABLE_MULDIV != 0) begin : g_muldiv
      logic w_mdSigned, w_mdIsDiv;
      assign w_mdSigned = (w_op == ALU_MULT) || (w_op == ALU_DIV);
      assign w_mdIsDiv  = (w_op == ALU_DIV)  || (w_op == ALU_DIVU);

      muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_mdStart),
        .i_signed (w_mdSigned),
        .i_isDiv  (w_mdIsDiv),
        .i_a      (A),
        .i_b      (B),
        .o_done   (w_mdDone),
        .o_hi     (w_mdHi),
        .o_lo     (w_mdLo)
      );
    end else begin : g_noMuldiv
      assign w_mdDone = 1'b0;
      assign w_mdHi   = '0;
      assign w_mdLo   = '0;
    end
  endgenerate

  // in_ready returns one cycle after the mult/div out_valid pulse, hence r_finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inReady  <= 1'b1;
      r_busy     <= 1'b0;
      r_finish   <= 1'b0;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_outValid <= 1'b0;
      r_finish   <= 1'b0;
      if (r_finish) begin
        r_inReady <= 1'b1;
        r_busy    <= 1'b0;
      end
      if (w_mdDone) begin
        r_hi       <= w_mdHi;
        r_lo       <= w_mdLo;
        r_result   <= w_mdLo;
        r_zero     <= ({w_mdHi, w_mdLo} == '0);
        r_overflow <= 1'b0;
        r_illegal  <= 1'b0;
        r_outValid <= 1'b1;
        r_finish   <= 1'b1;
      end else if (w_mdStart) begin
        r_inReady <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_accept) begin
        r_result   <= w_res;
        r_zero     <= (w_res == '0);
        r_overflow <= w_ovf;
        r_illegal  <= w_ill;
        r_outValid <= 1'b1;
      end
    end
  end

  assign in_ready  = r_inReady;
  assign busy      = r_busy;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule
